input_debouncer: RTL
====================

INPUT_DEBOUNCER -- requirements
Module: input_debouncer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, number of consecutive synchronized samples required before an output changes; legal range 2..2^24.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_a  input  1  raw asynchronous switch/button level, channel A.
REQ-005 in_b  input  1  raw asynchronous switch/button level, channel B.
REQ-006 a_db  output  1  debounced level, channel A; feeds the downstream two-input gate input a.
REQ-007 b_db  output  1  debounced level, channel B; feeds the downstream two-input gate input b.
REQ-008 a_rise, a_fall, b_rise, b_fall  output  1 each  single-cycle edge pulses of the debounced levels.

Function
REQ-009 Channels A and B SHALL be identical, independent instances of the logic below; no state is shared.
REQ-010 Each raw input SHALL pass through a 2-flop synchronizer; the second flop output (s) is the only value the channel FSM observes.
REQ-011 Each channel SHALL have a 4-state FSM: STABLE_LO, PEND_HI, STABLE_HI, PEND_LO, plus a counter of width $clog2(DEBOUNCE_CYCLES+1).
REQ-012 STABLE_LO: s=1 -> PEND_HI, cnt=1; s=0 -> stay, cnt=0.
REQ-013 PEND_HI: s=0 -> STABLE_LO, cnt=0 (bounce rejected); s=1 and cnt=DEBOUNCE_CYCLES-1 -> STABLE_HI, cnt=0; otherwise cnt+1.
REQ-014 STABLE_HI and PEND_LO SHALL mirror REQ-012/013 with the polarity of s inverted.
REQ-015 x_db SHALL be a registered output: 1 in STABLE_HI and PEND_LO, 0 in STABLE_LO and PEND_HI.
REQ-016 Latency: raw input held at a new level for K consecutive sampling edges changes x_db on the (DEBOUNCE_CYCLES+2)th edge; any excursion shorter than DEBOUNCE_CYCLES synchronized samples SHALL NOT change x_db.
REQ-017 Counter SHALL never exceed DEBOUNCE_CYCLES-1 and never wrap.
REQ-018 Simultaneous activity on in_a and in_b SHALL be processed independently with identical latency per channel.

Reset
REQ-019 rst_n=0 SHALL immediately clear synchronizers, counters, FSMs to STABLE_LO, and drive all outputs to 0, regardless of clk.
REQ-020 Assertion mid-debounce SHALL discard the pending transition; no pulse is emitted.
REQ-021 After rst_n deasserts, a raw input already high SHALL be debounced per REQ-016 from the first sampling edge, producing a normal rise.

Configuration
REQ-022 Macro DEBOUNCE_EDGE_PULSE_EN: when defined, x_rise SHALL be 1 for exactly one cycle on the cycle x_db goes 0->1, and x_fall for exactly one cycle on 1->0.
REQ-023 When DEBOUNCE_EDGE_PULSE_EN is undefined, all four pulse ports SHALL remain in the port list and be tied to constant 0; the edge-detect registers are not built.

Verification (DEBOUNCE_CYCLES=4, macro defined)
REQ-024 Reset then in_a=1 held from edge 1 -> a_db=1 and a_rise=1 after edge 6, a_rise=0 after edge 7; b_db stays 0.
REQ-025 in_a high for 3 edges then low -> a_db, a_rise never assert.
REQ-026 in_a bouncing 1,0,1,0 each edge for 8 edges then held 1 -> a_db rises exactly 6 edges after the last 0->1 sampling.
REQ-027 in_a and in_b both rise on the same edge and held -> a_db and b_db rise on the same edge; released together -> a_fall and b_fall pulse on the same cycle.
REQ-028 rst_n asserted 2 edges into a PEND_HI sequence -> all outputs 0 immediately, no pulse; after release with in_a held 1 -> a_db rises 6 edges later.
REQ-029 Same as REQ-024 with macro undefined -> a_db identical timing, a_rise/a_fall/b_rise/b_fall constant 0.

Source files
------------

// File: rtl/input_debouncer.sv
// Two-channel switch debouncer: 2-flop synchronizer plus a 4-state FSM per channel.
// Define DEBOUNCE_EDGE_PULSE_EN to build the single-cycle rise/fall pulse registers.
module input_debouncer #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic in_a,
   input  logic in_b,
   output logic a_db,
   output logic b_db,
   output logic a_rise,
   output logic a_fall,
   output logic b_rise,
   output logic b_fall
);

   localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CntW-1:0] CntOne  = CntW'(1);

   typedef enum logic [1:0] {StStableLo, StPendHi, StStableHi, StPendLo} state_e;

   logic [1:0] w_raw;
   logic [1:0] w_db;
   logic [1:0] w_rise;
   logic [1:0] w_fall;

   assign w_raw = {in_b, in_a};

   for (genvar gi = 0; gi < 2; gi++) begin : g_ch
      logic [1:0]      r_sync;
      state_e          r_state;
      logic [CntW-1:0] r_cnt;
      logic            r_db;
      logic            w_s;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_sync <= '0;
         end else begin
            r_sync <= {r_sync[0], w_raw[gi]};
         end
      end

      assign w_s = r_sync[1];

`ifdef DEBOUNCE_EDGE_PULSE_EN
      logic r_rise;
      logic r_fall;
`endif

      // r_cnt counts synchronized samples that disagree with the committed level.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_state <= StStableLo;
            r_cnt   <= '0;
            r_db    <= 1'b0;
`ifdef DEBOUNCE_EDGE_PULSE_EN
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
`endif
         end else begin
`ifdef DEBOUNCE_EDGE_PULSE_EN
            r_rise <= 1'b0;
            r_fall <= 1'b0;
`endif
            case (r_state)
               StStableLo: begin
                  if (w_s) begin
                     r_state <= StPendHi;
                     r_cnt   <= CntOne;
                  end else begin
                     r_cnt   <= '0;
                  end
               end
               StPendHi: begin
                  if (!w_s) begin
                     r_state <= StStableLo;
                     r_cnt   <= '0;
                  end else if (r_cnt == CntLast) begin
                     r_state <= StStableHi;
                     r_cnt   <= '0;
                     r_db    <= 1'b1;
`ifdef DEBOUNCE_EDGE_PULSE_EN
                     r_rise  <= 1'b1;
`endif
                  end else begin
                     r_cnt   <= r_cnt + CntOne;
                  end
               end
               StStableHi: begin
                  if (!w_s) begin
                     r_state <= StPendLo;
                     r_cnt   <= CntOne;
                  end else begin
                     r_cnt   <= '0;
                  end
               end
               StPendLo: begin
                  if (w_s) begin
                     r_state <= StStableHi;
                     r_cnt   <= '0;
                  end else if (r_cnt == CntLast) begin
                     r_state <= StStableLo;
                     r_cnt   <= '0;
                     r_db    <= 1'b0;
`ifdef DEBOUNCE_EDGE_PULSE_EN
                     r_fall  <= 1'b1;
`endif
                  end else begin
                     r_cnt   <= r_cnt + CntOne;
                  end
               end
               default: begin
                  r_state <= StStableLo;
                  r_cnt   <= '0;
                  r_db    <= 1'b0;
               end
            endcase
         end
      end

      assign w_db[gi] = r_db;
`ifdef DEBOUNCE_EDGE_PULSE_EN
      assign w_rise[gi] = r_rise;
      assign w_fall[gi] = r_fall;
`else
      assign w_rise[gi] = 1'b0;
      assign w_fall[gi] = 1'b0;
`endif
   end

   assign a_db   = w_db[0];
   assign b_db   = w_db[1];
   assign a_rise = w_rise[0];
   assign a_fall = w_fall[0];
   assign b_rise = w_rise[1];
   assign b_fall = w_fall[1];

endmodule
